// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, parity types, default width.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload register and bit index for the UART transmitter; rotates LSB-first so the
// latched payload (and its XOR) is intact again once the last bit has been sent.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic                  first_bit_c,
    output logic                  next_bit_c,
    output logic                  done_c,
    output logic                  xor_c
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    assign first_bit_c = data_q[0];
    assign next_bit_c  = data_q[1];
    assign done_c      = (idx_q == IDX_W'(DATA_WIDTH - 1));
    assign xor_c       = ^data_q;

    // Index clears on the shift that ends the data phase.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = load_data;
            idx_d  = '0;
        end else if (shift) begin
            data_d = {data_q[0], data_q[DATA_WIDTH-1:1]};
            idx_d  = done_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit; one bit per CLK.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    state_e state_q, state_d;
    logic   tx_out_q, tx_out_d;
    logic   busy_q, busy_d;
    logic   ser_load, ser_shift;
    logic   ser_first, ser_next, ser_done, ser_xor;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    logic unused_c;
    assign unused_c = ^{PAR_EN, PAR_TYP, ser_xor};
`endif

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk         (CLK),
        .rst         (RST),
        .load        (ser_load),
        .load_data   (P_DATA),
        .shift       (ser_shift),
        .first_bit_c (ser_first),
        .next_bit_c  (ser_next),
        .done_c      (ser_done),
        .xor_c       (ser_xor)
    );

    // Outputs are computed for the state being entered so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        tx_out_d  = 1'b1;
        busy_d    = 1'b1;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_d   = ST_START;
                    tx_out_d  = 1'b0;
                    ser_load  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                state_d  = ST_DATA;
                tx_out_d = ser_first;
            end
            ST_DATA: begin
                ser_shift = 1'b1;
                if (!ser_done) begin
                    tx_out_d = ser_next;
`ifdef UART_TX_PARITY_EN
                end else if (par_en_q) begin
                    state_d  = ST_PARITY;
                    tx_out_d = ser_xor ^ (par_typ_q == PAR_ODD);
`endif
                end else begin
                    state_d = ST_STOP;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
`endif
        end else begin
            state_q   <= state_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks;
    int failures;

    logic [0:15] seq;
    int          len;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, act, exp);
        end
    endtask

    // Called at the negedge inside the START cycle; returns at the negedge of the following IDLE cycle.
    task automatic check_frame(input string tag, input logic [0:15] s, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx%0d", tag, i), TX_OUT, s[i]);
            chk($sformatf("%s_busy%0d", tag, i), Busy, 1'b1);
            @(negedge CLK);
        end
        chk({tag, "_idle_tx"}, TX_OUT, 1'b1);
        chk({tag, "_idle_busy"}, Busy, 1'b0);
    endtask

    task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        #1;
        chk("reset_tx", TX_OUT, 1'b1);
        chk("reset_busy", Busy, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_hold_tx", TX_OUT, 1'b1);
        RST = 1'b0;

        // 0xA5 without parity, accepted on the first edge after reset release
        launch(8'hA5, 1'b0, 1'b0);
        seq = {10'b0101001011, 6'b0};
        check_frame("a5_nopar", seq, 10);

        // 0xA5 with PAR_EN=1, even then odd parity
        launch(8'hA5, 1'b1, 1'b0);
`ifdef UART_TX_PARITY_EN
        seq = {11'b01010010101, 5'b0};
        len = 11;
`else
        seq = {10'b0101001011, 6'b0};
        len = 10;
`endif
        check_frame("a5_even", seq, len);

        launch(8'hA5, 1'b1, 1'b1);
`ifdef UART_TX_PARITY_EN
        seq = {11'b01010010111, 5'b0};
        len = 11;
`else
        seq = {10'b0101001011, 6'b0};
        len = 10;
`endif
        check_frame("a5_odd", seq, len);

        // 0x07 even parity: three ones give parity 1
        launch(8'h07, 1'b1, 1'b0);
`ifdef UART_TX_PARITY_EN
        seq = {11'b01110000011, 5'b0};
        len = 11;
`else
        seq = {10'b0111000001, 6'b0};
        len = 10;
`endif
        check_frame("07_even", seq, len);

        // Data_Valid held, payload and config changed mid-frame
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA  = 8'h3C;
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b1;
        seq = {10'b0101001011, 6'b0};
        check_frame("hold_a5", seq, 10);
        @(negedge CLK);
        Data_Valid = 1'b0;
`ifdef UART_TX_PARITY_EN
        seq = {11'b00011110011, 5'b0};
        len = 11;
`else
        seq = {10'b0001111001, 6'b0};
        len = 10;
`endif
        check_frame("hold_3c", seq, len);

        // Asynchronous reset during data bit 3
        PAR_EN = 1'b0;
        launch(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge CLK);
        chk("bit3_tx", TX_OUT, 1'b0);
        chk("bit3_busy", Busy, 1'b1);
        RST = 1'b1;
        #1;
        chk("async_rst_tx", TX_OUT, 1'b1);
        chk("async_rst_busy", Busy, 1'b0);
        @(negedge CLK);
        chk("rst_held_tx", TX_OUT, 1'b1);
        chk("rst_held_busy", Busy, 1'b0);
        RST = 1'b0;

        launch(8'h3C, 1'b0, 1'b0);
        seq = {10'b0001111001, 6'b0};
        check_frame("post_rst_3c", seq, 10);

        @(negedge CLK);
        chk("final_idle_tx", TX_OUT, 1'b1);
        chk("final_idle_busy", Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 CLK  input  1  baud-rate clock; one serial bit per CLK cycle; all logic on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload; sampled only on frame acceptance.
REQ-005 Data_Valid  input  1  payload-valid strobe from the upstream block.
REQ-006 PAR_EN  input  1  1 = append a parity bit; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-008 TX_OUT  output  1  serial line, idle high; registered.
REQ-009 Busy  output  1  frame in progress; registered.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Acceptance: Data_Valid=1 while state=IDLE SHALL latch P_DATA, PAR_EN and PAR_TYP; the next cycle SHALL be START.
REQ-012 Data_Valid while state is not IDLE SHALL be ignored; no queuing, and the latched data and config SHALL stay unchanged.
REQ-013 IDLE: TX_OUT=1, Busy=0.
REQ-014 START: TX_OUT=0 for exactly one cycle, then DATA.
REQ-015 DATA: emit latched bits LSB first, one per cycle, for DATA_WIDTH cycles; a bit index counter SHALL run 0..DATA_WIDTH-1 and clear on leaving DATA.
REQ-016 After the last data bit the FSM SHALL go to PARITY if latched PAR_EN=1, otherwise to STOP.
REQ-017 PARITY: TX_OUT = XOR of latched data when PAR_TYP=0; the inverse of that XOR when PAR_TYP=1; lasts one cycle.
REQ-018 STOP: TX_OUT=1 for one cycle, then IDLE unconditionally.
REQ-019 Busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 only in IDLE.
REQ-020 Frame length from the first START cycle to the last STOP cycle SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
REQ-021 Back-to-back frames SHALL have at least one IDLE cycle (TX_OUT=1) between STOP and the next START.
REQ-022 Changes to P_DATA, PAR_EN or PAR_TYP during a frame SHALL NOT affect that frame.

Reset
REQ-023 RST=1 at any time, including mid-frame, SHALL immediately force state=IDLE, TX_OUT=1, Busy=0, bit index=0, and latched data/config=0.
REQ-024 The first acceptance SHALL be possible on the first CLK edge after RST deasserts.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state, PAR_EN and PAR_TYP behave as in REQ-016/017.
REQ-026 Macro undefined: no PARITY state or parity logic; PAR_EN and PAR_TYP ports remain but are ignored; frames are always DATA_WIDTH+2 bits.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encoding constants, the parity-type constants (EVEN=0, ODD=1) and the default DATA_WIDTH.
REQ-028 One sub-module, uart_tx_serializer: shift register plus bit index with load/shift/done ports; the FSM and output mux stay in uart_tx.

Verification
REQ-029 Reset, then P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high for exactly 10 cycles.
REQ-030 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-bit frame; repeat with PAR_TYP=1 -> parity bit 1.
REQ-031 P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1.
REQ-032 Hold Data_Valid=1 with P_DATA changed to 0x3C mid-frame -> current frame unchanged; next START only after at least one IDLE cycle; next frame carries 0x3C.
REQ-033 Assert RST during data bit 3 -> TX_OUT=1 and Busy=0 the same cycle, with no CLK edge required; the next Data_Valid yields a clean full frame.
REQ-034 Build without UART_TX_PARITY_EN and drive PAR_EN=1 with 0xA5 -> 10-bit frame identical to REQ-029.
